// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 load, per-round C/D rotation, PC-2 subkey.
// Encrypt walks K1..K16 by left rotation, decrypt K16..K1 by right rotation.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        next,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [47:0] sk_q, sk_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;

  // DES bit n of the key is key_in[64-n]; parity bits never appear
  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    pc1 = {
      k[7],  k[15], k[23], k[31],
      k[39], k[47], k[55], k[63],
      k[6],  k[14], k[22], k[30],
      k[38], k[46], k[54], k[62],
      k[5],  k[13], k[21], k[29],
      k[37], k[45], k[53], k[61],
      k[4],  k[12], k[20], k[28],
      k[1],  k[9],  k[17], k[25],
      k[33], k[41], k[49], k[57],
      k[2],  k[10], k[18], k[26],
      k[34], k[42], k[50], k[58],
      k[3],  k[11], k[19], k[27],
      k[35], k[43], k[51], k[59],
      k[36], k[44], k[52], k[60]
    };
  endfunction

  // CD bit n (C first) is cd[56-n]
  function automatic logic [47:0] pc2(
    input logic [27:0] c,
    input logic [27:0] d
  );
    logic [55:0] cd;
    cd = {c, d};
    pc2 = {
      cd[42], cd[39], cd[45], cd[32],
      cd[55], cd[51], cd[53], cd[28],
      cd[41], cd[50], cd[35], cd[46],
      cd[33], cd[37], cd[44], cd[52],
      cd[30], cd[48], cd[40], cd[49],
      cd[29], cd[36], cd[43], cd[54],
      cd[15], cd[4],  cd[25], cd[19],
      cd[9],  cd[1],  cd[26], cd[16],
      cd[5],  cd[11], cd[23], cd[8],
      cd[12], cd[7],  cd[17], cd[0],
      cd[22], cd[3],  cd[10], cd[14],
      cd[6],  cd[20], cd[27], cd[24]
    };
  endfunction

  function automatic logic [27:0] rotl(
    input logic [27:0] x,
    input logic        one
  );
    if (one)
      rotl = {x[26:0], x[27]};
    else
      rotl = {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(
    input logic [27:0] x,
    input logic        one
  );
    if (one)
      rotr = {x[0], x[27:1]};
    else
      rotr = {x[1:0], x[27:2]};
  endfunction

  // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) shift by one
  function automatic logic one_sh(
    input logic [3:0] r
  );
    one_sh = (r == 4'd0) || (r == 4'd1) ||
             (r == 4'd8) || (r == 4'd15);
  endfunction

  logic [55:0] pc1_w;
  logic [27:0] c0_w, d0_w;
  logic [27:0] cl_w, dl_w;
  logic [27:0] cs_w, ds_w;
  logic [3:0]  inc_w, dec_w;
  logic        one_w;

  assign pc1_w = pc1(key_in);
  assign c0_w  = pc1_w[55:28];
  assign d0_w  = pc1_w[27:0];
  assign cl_w  = rotl(c0_w, 1'b1);
  assign dl_w  = rotl(d0_w, 1'b1);
  assign inc_w = idx_q + 4'd1;
  assign dec_w = idx_q - 4'd1;

  // Decrypt undoes the shift that produced the current round;
  // encrypt applies the shift of the following round.
  assign one_w = dec_q ? one_sh(idx_q) : one_sh(inc_w);

  // Next round's halves, rotate-by-2 done in a single step
  always_comb begin
    if (dec_q) begin
      cs_w = rotr(c_q, one_w);
      ds_w = rotr(d_q, one_w);
    end else begin
      cs_w = rotl(c_q, one_w);
      ds_w = rotl(d_q, one_w);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      sk_q    <= 48'd0;
      idx_q   <= 4'd0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      c_q     <= c_d;
      d_q     <= d_d;
      sk_q    <= sk_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load always (re)starts, 16th accept returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load)
          state_d = RUN;
      end
      RUN: begin
        if (load)
          state_d = RUN;
        else if (next && step_q == 4'd15)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; load has priority over next
  always_comb begin
    step_d = step_q;
    c_d    = c_q;
    d_d    = d_q;
    sk_d   = sk_q;
    idx_d  = idx_q;
    dec_d  = dec_q;
    done_d = 1'b0;
    if (load) begin
      step_d = 4'd0;
      dec_d  = decrypt;
      if (decrypt) begin
        c_d   = c0_w;
        d_d   = d0_w;
        sk_d  = pc2(c0_w, d0_w);
        idx_d = 4'd15;
      end else begin
        c_d   = cl_w;
        d_d   = dl_w;
        sk_d  = pc2(cl_w, dl_w);
        idx_d = 4'd0;
      end
    end else if (state_q == RUN && next) begin
      if (step_q == 4'd15) begin
        done_d = 1'b1;
      end else begin
        step_d = step_q + 4'd1;
        c_d    = cs_w;
        d_d    = ds_w;
        sk_d   = pc2(cs_w, ds_w);
        idx_d  = dec_q ? dec_w : inc_w;
      end
    end
  end

  // Outputs
  always_comb begin
    subkey       = sk_q;
    round_idx    = idx_q;
    done         = done_q;
    subkey_valid = (state_q == RUN);
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic
// 133457799BBCDFF1 schedule plus weak keys with constant subkeys.
module tb_des_key_sched;

  logic        clk;
  logic        rst;
  logic        load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        next;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        done;

  int chks;
  int errs;

  logic [47:0] ks [16];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_W1 = 64'h1F1F1F1F0E0E0E0E;
  localparam logic [63:0] KEY_W2 = 64'hE0E0E0E0F1F1F1F1;

  des_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .next         (next),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    chks++;
    if (subkey !== 48'd0 || subkey_valid !== 1'b0 ||
        round_idx !== 4'd0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset sk=%h v=%b idx=%0d d=%b want 0",
               subkey, subkey_valid, round_idx, done);
    end
    rst = 1'b0;
    next = 1'b1;
    tick();
    tick();
    next = 1'b0;
    chks++;
    if (subkey_valid !== 1'b0 || done !== 1'b0 ||
        subkey !== 48'd0) begin
      errs++;
      $display("FAIL idle_next v=%b d=%b sk=%h want 0 0 0",
               subkey_valid, done, subkey);
    end
  endtask

  task automatic test_parity();
    load = 1'b1;
    key_in = 64'h0101010101010101;
    decrypt = 1'b0;
    tick();
    chks++;
    if (subkey !== 48'd0 || subkey_valid !== 1'b1) begin
      errs++;
      $display("FAIL parity0 sk=%h v=%b want 0 1",
               subkey, subkey_valid);
    end
    key_in = 64'hFEFEFEFEFEFEFEFE;
    tick();
    load = 1'b0;
    chks++;
    if (subkey !== 48'hFFFFFFFFFFFF) begin
      errs++;
      $display("FAIL parity1 sk=%h want ffffffffffff", subkey);
    end
  endtask

  task automatic test_encrypt();
    load = 1'b1;
    key_in = KEY_A;
    decrypt = 1'b0;
    tick();
    load = 1'b0;
    chks++;
    if (subkey !== ks[0] || round_idx !== 4'd0 ||
        subkey_valid !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL enc_k1 sk=%h idx=%0d v=%b want %h 0 1",
               subkey, round_idx, subkey_valid, ks[0]);
    end
    next = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chks++;
      if (subkey !== ks[i] || round_idx !== 4'(i) ||
          subkey_valid !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL enc_k%0d sk=%h idx=%0d v=%b want %h %0d",
                 i + 1, subkey, round_idx, subkey_valid, ks[i], i);
      end
    end
    tick();
    next = 1'b0;
    chks++;
    if (done !== 1'b1 || subkey_valid !== 1'b0 ||
        subkey !== ks[15]) begin
      errs++;
      $display("FAIL enc_done d=%b v=%b sk=%h want 1 0 %h",
               done, subkey_valid, subkey, ks[15]);
    end
    tick();
    chks++;
    if (done !== 1'b0 || subkey_valid !== 1'b0) begin
      errs++;
      $display("FAIL enc_after d=%b v=%b want 0 0",
               done, subkey_valid);
    end
  endtask

  task automatic test_decrypt();
    load = 1'b1;
    key_in = KEY_A;
    decrypt = 1'b1;
    tick();
    load = 1'b0;
    decrypt = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chks++;
      if (subkey !== ks[15 - i] || round_idx !== 4'(15 - i) ||
          subkey_valid !== 1'b1) begin
        errs++;
        $display("FAIL dec_%0d sk=%h idx=%0d v=%b want %h %0d",
                 i, subkey, round_idx, subkey_valid,
                 ks[15 - i], 15 - i);
      end
      tick();
    end
    next = 1'b0;
    chks++;
    if (done !== 1'b1 || subkey_valid !== 1'b0) begin
      errs++;
      $display("FAIL dec_done d=%b v=%b want 1 0",
               done, subkey_valid);
    end
    tick();
  endtask

  task automatic test_gaps();
    logic [31:0] pat;
    int          e;
    logic        fin;
    logic        nb;
    pat = 32'hA5C39E61;
    e = 0;
    fin = 1'b0;
    load = 1'b1;
    key_in = KEY_A;
    decrypt = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      nb = pat[c % 32];
      next = nb;
      tick();
      if (nb) begin
        if (e == 15) begin
          fin = 1'b1;
          chks++;
          if (done !== 1'b1 || subkey_valid !== 1'b0) begin
            errs++;
            $display("FAIL gap_done d=%b v=%b want 1 0",
                     done, subkey_valid);
          end
        end else begin
          e++;
        end
      end
      if (!fin) begin
        chks++;
        if (subkey !== ks[e] || round_idx !== 4'(e) ||
            subkey_valid !== 1'b1 || done !== 1'b0) begin
          errs++;
          $display("FAIL gap_c%0d sk=%h idx=%0d want %h %0d",
                   c, subkey, round_idx, ks[e], e);
        end
      end
    end
    next = 1'b0;
    if (!fin) begin
      errs++;
      $display("FAIL gap_timeout idx=%0d want done", round_idx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    load = 1'b1;
    key_in = KEY_A;
    decrypt = 1'b0;
    tick();
    load = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 7; i++)
      tick();
    chks++;
    if (round_idx !== 4'd7 || subkey !== ks[7]) begin
      errs++;
      $display("FAIL b2b_mid idx=%0d sk=%h want 7 %h",
               round_idx, subkey, ks[7]);
    end
    load = 1'b1;
    key_in = KEY_W1;
    tick();
    load = 1'b0;
    chks++;
    if (subkey !== 48'h000000FFFFFF || round_idx !== 4'd0 ||
        subkey_valid !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL reload sk=%h idx=%0d v=%b d=%b want 000000ffffff 0 1 0",
               subkey, round_idx, subkey_valid, done);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      chks++;
      if (subkey !== 48'h000000FFFFFF || round_idx !== 4'(i) ||
          done !== 1'b0) begin
        errs++;
        $display("FAIL w1_%0d sk=%h idx=%0d d=%b want 000000ffffff %0d 0",
                 i, subkey, round_idx, done, i);
      end
    end
    tick();
    next = 1'b0;
    chks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL w1_done d=%b want 1", done);
    end
    load = 1'b1;
    key_in = KEY_W2;
    decrypt = 1'b1;
    tick();
    load = 1'b0;
    decrypt = 1'b0;
    chks++;
    if (subkey !== 48'hFFFFFF000000 || round_idx !== 4'd15 ||
        subkey_valid !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL load_on_done sk=%h idx=%0d v=%b d=%b want ffffff000000 15 1 0",
               subkey, round_idx, subkey_valid, done);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    chks++;
    if (subkey !== 48'hFFFFFF000000 || round_idx !== 4'd14) begin
      errs++;
      $display("FAIL w2_step sk=%h idx=%0d want ffffff000000 14",
               subkey, round_idx);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1;
    key_in = KEY_A;
    decrypt = 1'b0;
    tick();
    load = 1'b0;
    next = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chks++;
    if (subkey !== 48'd0 || subkey_valid !== 1'b0 ||
        round_idx !== 4'd0 || done !== 1'b0) begin
      errs++;
      $display("FAIL async_rst sk=%h v=%b idx=%0d d=%b want 0",
               subkey, subkey_valid, round_idx, done);
    end
    #3;
    rst = 1'b0;
    tick();
    tick();
    chks++;
    if (subkey_valid !== 1'b0 || subkey !== 48'd0 ||
        round_idx !== 4'd0) begin
      errs++;
      $display("FAIL rst_next v=%b sk=%h idx=%0d want 0",
               subkey_valid, subkey, round_idx);
    end
    next = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chks++;
    if (subkey !== ks[0] || subkey_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_reload sk=%h v=%b want %h 1",
               subkey, subkey_valid, ks[0]);
    end
  endtask

  initial begin
    chks = 0;
    errs = 0;
    ks[0]  = 48'h1B02EFFC7072;
    ks[1]  = 48'h79AED9DBC9E5;
    ks[2]  = 48'h55FC8A42CF99;
    ks[3]  = 48'h72ADD6DB351D;
    ks[4]  = 48'h7CEC07EB53A8;
    ks[5]  = 48'h63A53E507B2F;
    ks[6]  = 48'hEC84B7F618BC;
    ks[7]  = 48'hF78A3AC13BFB;
    ks[8]  = 48'hE0DBEBEDE781;
    ks[9]  = 48'hB1F347BA464F;
    ks[10] = 48'h215FD3DED386;
    ks[11] = 48'h7571F59467E9;
    ks[12] = 48'h97C5D1FABA41;
    ks[13] = 48'h5F43B7F2E73A;
    ks[14] = 48'hBF918D3D3F0A;
    ks[15] = 48'hCB3D8B0E17F5;
    rst = 1'b1;
    load = 1'b0;
    key_in = 64'd0;
    decrypt = 1'b0;
    next = 1'b0;
    test_reset();
    test_parity();
    test_encrypt();
    test_decrypt();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
